// File: rtl/opcode_fetch_pkg.sv
// opcode_fetch_pkg: shared state, length and EA offset encodings for the instruction fetcher
package opcode_fetch_pkg;
  typedef enum logic [2:0] {
    FS_FETCH_OP,
    FS_FETCH_PB,
    FS_FETCH_EA,
    FS_FETCH_OFS,
    FS_FETCH_OPND,
    FS_HOLD
  } fs_t;
  typedef enum logic [1:0] {OPLEN_0, OPLEN_1, OPLEN_2, OPLEN_IDX} oplen_t;
  typedef enum logic [1:0] {EAOFS_0, EAOFS_1, EAOFS_2} eaofs_t;
  localparam logic [7:0] PFX_PAGE2 = 8'h10;
  localparam logic [7:0] PFX_PAGE3 = 8'h11;
endpackage

// File: rtl/opcode_fetch_length.sv
// opcode_fetch_length: operand length of an opcode and offset length of an indexed postbyte
module opcode_fetch_length
  import opcode_fetch_pkg::*;
(
  input  logic [7:0] op,
  input  logic       paged,
  input  logic [7:0] ea,
  output oplen_t     len,
  output eaofs_t     ofs
);
  logic [3:0] lo;
  assign lo = op[3:0];
  always_comb begin
    len = OPLEN_0;
    if (paged) begin
      case (op[7:4])
        4'h2, 4'h8, 4'hB, 4'hC, 4'hF: len = OPLEN_2;
        4'h9, 4'hD:                   len = OPLEN_1;
        4'hA, 4'hE:                   len = OPLEN_IDX;
        default:                      len = OPLEN_0;
      endcase
    end else begin
      case (op[7:4])
        4'h7, 4'hB, 4'hF:       len = OPLEN_2;
        4'h0, 4'h2, 4'h9, 4'hD: len = OPLEN_1;
        4'h6, 4'hA, 4'hE:       len = OPLEN_IDX;
        4'h1: len = (lo[3:1] == 3'b011) ? OPLEN_2 :
                    (lo == 4'hA || lo == 4'hC || lo == 4'hE || lo == 4'hF) ? OPLEN_1 : OPLEN_0;
        4'h3: len = (lo[3:2] == 2'b00) ? OPLEN_IDX :
                    (lo[3:2] == 2'b01 || lo == 4'hC) ? OPLEN_1 : OPLEN_0;
        4'h8, 4'hC: len = (lo == 4'h3 || lo == 4'hC || lo == 4'hE) ? OPLEN_2 : OPLEN_1;
        default: len = OPLEN_0;
      endcase
    end
  end
  assign ofs = !ea[7] ? EAOFS_0 :
               (ea[3:0] == 4'h8 || ea[3:0] == 4'hC) ? EAOFS_1 :
               (ea[3:0] == 4'h9 || ea[3:0] == 4'hD || ea[4:0] == 5'h1F) ? EAOFS_2 : EAOFS_0;
endmodule

// File: rtl/opcode_fetch.sv
// opcode_fetch: assembles prefixed/indexed instructions byte by byte and hands them over via valid/ready
module opcode_fetch
  import opcode_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'hFFFE
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  input  logic        load_pc,
  input  logic [15:0] new_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  opcode,
  output logic [7:0]  postbyte0,
  output logic        page2_valid,
  output logic        page3_valid,
  output logic [7:0]  eapostbyte,
  output logic [15:0] ea_ofs,
  output logic [15:0] operand,
  output logic [15:0] ins_pc,
  output logic [15:0] next_pc
);
  fs_t         state;
  logic [15:0] pc;
  logic [1:0]  rem;
  logic        started;
  logic        take;
  logic        is_pfx;
  oplen_t      len;
  eaofs_t      ofs;
  opcode_fetch_length u_len (
    .op    (mem_data),
    .paged (state == FS_FETCH_PB),
    .ea    (mem_data),
    .len   (len),
    .ofs   (ofs)
  );
  assign mem_addr  = pc;
  assign mem_rd    = started && state != FS_HOLD;
  assign ins_valid = state == FS_HOLD;
  assign take      = mem_rd && mem_ack && !load_pc;
  assign is_pfx    = mem_data == PFX_PAGE2 || mem_data == PFX_PAGE3;
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset || load_pc) begin
      state       <= FS_FETCH_OP;
      pc          <= cpu_reset ? RESET_PC : new_pc;
      started     <= !cpu_reset;
      rem         <= 2'd0;
      opcode      <= 8'h00;
      postbyte0   <= 8'h00;
      page2_valid <= 1'b0;
      page3_valid <= 1'b0;
      eapostbyte  <= 8'h00;
      ea_ofs      <= 16'h0000;
      operand     <= 16'h0000;
      ins_pc      <= 16'h0000;
      next_pc     <= 16'h0000;
    end else if (state == FS_HOLD) begin
      if (ins_ready) begin
        state       <= FS_FETCH_OP;
        page2_valid <= 1'b0;
        page3_valid <= 1'b0;
        eapostbyte  <= 8'h00;
        ea_ofs      <= 16'h0000;
        operand     <= 16'h0000;
      end
    end else begin
      started <= 1'b1;
      if (take) begin
        pc      <= pc + 16'd1;
        next_pc <= pc + 16'd1;
        case (state)
          FS_FETCH_OP, FS_FETCH_PB: begin
            if (state == FS_FETCH_OP) ins_pc <= pc;
            if (is_pfx) begin
              opcode      <= mem_data;
              page2_valid <= !mem_data[0];
              page3_valid <= mem_data[0];
              state       <= FS_FETCH_PB;
            end else begin
              if (state == FS_FETCH_OP) opcode <= mem_data;
              postbyte0 <= (state == FS_FETCH_PB) ? mem_data : 8'h00;
              rem       <= (len == OPLEN_2) ? 2'd2 : 2'd1;
              state     <= (len == OPLEN_0) ? FS_HOLD : (len == OPLEN_IDX) ? FS_FETCH_EA : FS_FETCH_OPND;
            end
          end
          FS_FETCH_EA: begin
            eapostbyte <= mem_data;
            rem        <= (ofs == EAOFS_2) ? 2'd2 : 2'd1;
            state      <= (ofs == EAOFS_0) ? FS_HOLD : FS_FETCH_OFS;
          end
          FS_FETCH_OFS: begin
            ea_ofs <= {ea_ofs[7:0], mem_data};
            rem    <= rem - 2'd1;
            state  <= (rem == 2'd1) ? FS_HOLD : FS_FETCH_OFS;
          end
          FS_FETCH_OPND: begin
            operand <= {operand[7:0], mem_data};
            rem     <= rem - 2'd1;
            state   <= (rem == 2'd1) ? FS_HOLD : FS_FETCH_OPND;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/opcode_fetch.md
Name: opcode_fetch

Overview:
- Sequential instruction-byte assembler feeding the page-1/2/3 decoders.
- Reads instruction bytes from memory at the current PC and folds 0x10/0x11 prefixes into page2/page3 flags.
- Collects the indexed EA postbyte, the EA offset and the immediate/direct/extended/relative operand bytes.
- Presents one complete instruction per valid/ready handshake to the execute sequencer.

Parameters:
- RESET_PC, 16'hFFFE, PC loaded on reset (vector fetch address; the sequencer redirects after the vector read).

Ports:
- cpu_clk  input  1  clock
- cpu_reset  input  1  synchronous active-high reset
- mem_addr  output  16  byte address of the current fetch
- mem_rd  output  1  read request; held with mem_addr stable until mem_ack
- mem_data  input  8  read data, valid when mem_ack=1
- mem_ack  input  1  one-cycle read acknowledge
- load_pc  input  1  redirect (branch/jump/interrupt); highest priority
- new_pc  input  16  redirect target
- ins_valid  output  1  instruction fields valid
- ins_ready  input  1  consumer accepts the instruction
- opcode  output  8  first non-prefix byte (the prefix byte itself when a page is active)
- postbyte0  output  8  byte after the prefix
- page2_valid, page3_valid  output  1 each  prefix 0x10 / 0x11 seen
- eapostbyte  output  8  indexed postbyte (0 when not indexed)
- ea_ofs  output  16  EA offset; 1 byte in [7:0] with [15:8]=0; 2 bytes big-endian
- operand  output  16  same packing rule as ea_ofs
- ins_pc  output  16  address of the first instruction byte
- next_pc  output  16  address after the last instruction byte

Behaviour:
- Reset: all outputs 0 except mem_addr=RESET_PC; pc=RESET_PC; state FETCH_OP. Reset mid-fetch abandons the request.
- States: FETCH_OP, FETCH_PB, FETCH_EA, FETCH_OFS, FETCH_OPND, HOLD.
- Each fetch state asserts mem_rd with mem_addr=pc. On mem_ack it latches the byte, pc+1 (16-bit wrap FFFF->0000), and moves on.
- Minimum one cycle per byte; a back-to-back ack is allowed.
- FETCH_OP:
  - Byte 0x10 -> page2=1, opcode=0x10, go FETCH_PB.
  - Byte 0x11 -> page3=1, opcode=0x11, go FETCH_PB.
  - Otherwise decode the length.
- FETCH_PB:
  - A further 0x10/0x11 is consumed; the latest prefix wins, page flags are updated and the state stays FETCH_PB.
  - Otherwise latch postbyte0 and decode the length.
- Length decode (op = postbyte0 if a page is active, else opcode):
  - Page1, 2 operand bytes: 0x16, 0x17, 0x7x, 0xBx, 0xFx, 0xC3, 0xCC, 0xCE, 0x83, 0x8C, 0x8E.
  - Page1, 1 operand byte: 0x0x, 0x2x, 0x9x, 0xDx, 0x1A, 0x1C, 0x1E, 0x1F, 0x34–0x37, 0x3C, and all other 0x8x/0xCx.
  - Page1, indexed: 0x30–0x33, 0x6x, 0xAx, 0xEx.
  - Page1: everything else has 0 operand bytes.
  - Page2/3, 2 operand bytes: 0x2x, 0x8x, 0xCx, 0xBx, 0xFx.
  - Page2/3, 1 operand byte: 0x9x, 0xDx.
  - Page2/3, indexed: 0xAx, 0xEx.
  - Page2/3: everything else has 0 operand bytes.
- Indexed path: FETCH_EA, then offset length from the postbyte:
  - 1 byte: 1xxx1000, 1xxx1100.
  - 2 bytes: 1xxx1001, 1xxx1101, 1xx11111.
  - 0 bytes: everything else.
  - Offset bytes go through FETCH_OFS; indexed instructions carry no further operand bytes.
- Zero remaining bytes go directly to HOLD. ins_valid=1 only in HOLD; fields stay stable until ins_valid & ins_ready.
- On the handshake cycle, clear the page flags, eapostbyte, ea_ofs and operand, then go to FETCH_OP. Fetch of the next instruction starts the following cycle; fetch never overlaps HOLD.
- load_pc=1, in any state:
  - Next cycle: pc=new_pc, state=FETCH_OP, ins_valid=0, partial fields cleared.
  - An ack in the same cycle is discarded.
  - A simultaneous ins_ready handshake is ignored.
- next_pc = pc after the final byte; ins_pc is captured at FETCH_OP entry.

Decomposition:
- defs.v additions: FSM state encodings (FS_*); length codes OPLEN_0/1/2/IDX; EA offset codes EAOFS_0/1/2.
- Sub-module opcode_length (combinational): op, page flags -> length code. Its EA postbyte -> offset length logic is shared in the same sub-module.

Test Plan:
- Bytes 86 42 at 0x1000 (LDA #) -> opcode=86, operand=0x0042, ins_pc=1000, next_pc=1002, ins_valid after 2 acks.
- Bytes 10 8E 12 34 (LDY #) -> page2=1, postbyte0=8E, operand=1234, next_pc=+4; same bytes with 11 prefix set page3 instead.
- Bytes A6 89 01 00 (LDA 256,X) -> eapostbyte=89, ea_ofs=0100, operand=0; bytes A6 84 -> ea_ofs=0, next_pc=+2.
- Bytes 10 11 10 27 00 10 -> page2=1 only, postbyte0=27, operand=0010; ins_ready held low 5 cycles -> fields stable.
- load_pc=1, new_pc=2000 in the same cycle as the ack of the second byte of 8E xx -> byte discarded, mem_addr=2000 next cycle, ins_valid stays 0.
- Opcode 12 at FFFF -> next_pc=0000; cpu_reset mid-FETCH_OPND -> mem_addr=FFFE, all outputs 0.
